// File: rtl/serial_cmd_rx_if.sv
// rtl/serial_cmd_rx_if.sv - Wishbone master/slave signal bundle for serial_cmd_rx
//
// Purpose: groups the single-beat Wishbone handshake between the serial
// command receiver (master) and the slave mux (slave).
// Signals:
//   stb_o  master strobe
//   we_o   write enable (1 = write, 0 = read)
//   adr_o  address, [7:4] channel, [3:0] register
//   dat_o  write data
//   dat_i  read data returned by the slave
//   ack_i  slave acknowledge
interface serial_cmd_rx_if;
  logic       stb_o;
  logic       we_o;
  logic [7:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;

  modport master (
    output stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/serial_cmd_rx.sv
// rtl/serial_cmd_rx.sv - 8N1 serial command receiver driving a Wishbone master cycle
//
// Purpose: receives opcode/address/data bytes on rxd and turns each complete
// command into one Wishbone bus cycle. 0x57 = write (opcode, addr, data),
// 0x52 = read (opcode, addr).
// Parameters:
//   BIT_CYCLES   clk_i cycles per serial bit (4..255)
//   ACK_TIMEOUT  cycles stb_o may wait for ack_i before the cycle is abandoned
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-low reset
//   rxd       asynchronous serial input, idle high, LSB first
//   wb        Wishbone master side (stb_o, we_o, adr_o, dat_o, dat_i, ack_i)
//   rd_dat_o  data of the last completed read
//   rd_vld_o  one-cycle pulse when rd_dat_o updates
//   err_o     one-cycle pulse on framing error, bad opcode, dropped byte, ack timeout
//   busy_o    high while a command is being assembled or executed
module serial_cmd_rx #(
  parameter int BIT_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rxd,
  serial_cmd_rx_if.master        wb,
  output logic [7:0]             rd_dat_o,
  output logic                   rd_vld_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam logic [7:0] HALF_M1 = 8'(BIT_CYCLES / 2 - 1);
  localparam logic [7:0] FULL_M1 = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] TMO_M1  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_BUS}  p_state_t;

  r_state_t   r_state;
  p_state_t   p_state;

  logic       rxd_meta, rxd_sync, rxd_prev;
  logic [7:0] r_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       stop_seen;
  logic       byte_stb;
  logic [7:0] byte_dat;
  logic       frame_err;

  logic       is_wr;
  logic [7:0] tmo_cnt;

  // Receiver. The synchronizer and edge history reset low so that a line
  // already held low out of reset never looks like a start edge; a real
  // high level has to be seen first.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rxd_meta  <= 1'b0;
      rxd_sync  <= 1'b0;
      rxd_prev  <= 1'b0;
      r_state   <= R_IDLE;
      r_cnt     <= 8'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      stop_seen <= 1'b0;
      byte_stb  <= 1'b0;
      byte_dat  <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      rxd_meta  <= rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            r_state <= R_START;
            r_cnt   <= 8'd0;
          end
        end
        R_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= 8'd0;
            bit_idx <= 3'd0;
            // a start bit that is already high again was a glitch
            r_state <= rxd_sync ? R_IDLE : R_DATA;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        R_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= 8'd0;
            shift <= {rxd_sync, shift[7:1]};
            if (bit_idx == 3'd7) r_state <= R_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        R_STOP: begin
          if (!stop_seen) begin
            if (r_cnt == FULL_M1) begin
              r_cnt     <= 8'd0;
              stop_seen <= 1'b1;
              if (rxd_sync) begin
                byte_stb <= 1'b1;
                byte_dat <= shift;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (rxd_sync) begin
            // a broken stop bit may hold the line low; rearm only once it idles
            stop_seen <= 1'b0;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Command parser and bus master.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      p_state  <= P_IDLE;
      is_wr    <= 1'b0;
      tmo_cnt  <= 8'd0;
      wb.stb_o <= 1'b0;
      wb.we_o  <= 1'b0;
      wb.adr_o <= 8'd0;
      wb.dat_o <= 8'd0;
      rd_dat_o <= 8'd0;
      rd_vld_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rd_vld_o <= 1'b0;
      err_o    <= frame_err;
      case (p_state)
        P_IDLE: begin
          if (byte_stb) begin
            if (byte_dat == OP_WR) begin
              is_wr   <= 1'b1;
              p_state <= P_ADDR;
            end else if (byte_dat == OP_RD) begin
              is_wr   <= 1'b0;
              p_state <= P_ADDR;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        P_ADDR: begin
          if (frame_err) begin
            p_state <= P_IDLE;
          end else if (byte_stb) begin
            wb.adr_o <= byte_dat;
            if (is_wr) begin
              p_state <= P_DATA;
            end else begin
              p_state  <= P_BUS;
              wb.stb_o <= 1'b1;
              wb.we_o  <= 1'b0;
              tmo_cnt  <= 8'd0;
            end
          end
        end
        P_DATA: begin
          if (frame_err) begin
            p_state <= P_IDLE;
          end else if (byte_stb) begin
            wb.dat_o <= byte_dat;
            p_state  <= P_BUS;
            wb.stb_o <= 1'b1;
            wb.we_o  <= 1'b1;
            tmo_cnt  <= 8'd0;
          end
        end
        P_BUS: begin
          // Bytes or framing errors arriving now only flag err_o; the
          // handshake already on the bus is left to finish on its own.
          if (byte_stb) err_o <= 1'b1;
          if (wb.ack_i) begin
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            p_state  <= P_IDLE;
            if (!is_wr) begin
              rd_dat_o <= wb.dat_i;
              rd_vld_o <= 1'b1;
            end
          end else if (tmo_cnt == TMO_M1) begin
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            err_o    <= 1'b1;
            p_state  <= P_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  assign busy_o = (p_state != P_IDLE);

endmodule

// File: tb/tb_serial_cmd_rx.sv
// tb/tb_serial_cmd_rx.sv - self-checking bench for serial_cmd_rx
module tb_serial_cmd_rx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rxd;
  logic [7:0] rd_dat_o;
  logic       rd_vld_o;
  logic       err_o;
  logic       busy_o;

  serial_cmd_rx_if bus ();

  serial_cmd_rx #(.BIT_CYCLES(16), .ACK_TIMEOUT(255)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rxd      (rxd),
    .wb       (bus),
    .rd_dat_o (rd_dat_o),
    .rd_vld_o (rd_vld_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // slave behaviour, set by the stimulus; ack_delay 0 means never acknowledge
  int         ack_delay   = 2;
  logic [7:0] slave_rdata = 8'h00;
  int         slave_cnt   = 0;

  always @(negedge clk_i) begin
    if (bus.stb_o === 1'b1 && bus.ack_i !== 1'b1) begin
      slave_cnt = slave_cnt + 1;
      if (ack_delay != 0 && slave_cnt == ack_delay) begin
        bus.ack_i = 1'b1;
        bus.dat_i = slave_rdata;
      end
    end else begin
      bus.ack_i = 1'b0;
      bus.dat_i = ~slave_rdata;
      slave_cnt = 0;
    end
  end

  // passive monitor: event counts and per-strobe captures
  int         err_cnt  = 0;
  int         vld_hi   = 0;
  int         vld_rise = 0;
  int         stb_cnt  = 0;
  int         stb_len  = 0;
  int         unstable = 0;
  logic       stb_prev = 1'b0;
  logic       vld_prev = 1'b0;
  logic       cap_we;
  logic [7:0] cap_adr, cap_dat, last_rd;

  always @(negedge clk_i) begin
    if (err_o === 1'b1) err_cnt++;
    if (rd_vld_o === 1'b1) begin
      vld_hi++;
      last_rd = rd_dat_o;
      if (!vld_prev) vld_rise++;
    end
    vld_prev = (rd_vld_o === 1'b1);
    if (bus.stb_o === 1'b1) begin
      if (!stb_prev) begin
        stb_cnt++;
        stb_len = 0;
        cap_we  = bus.we_o;
        cap_adr = bus.adr_o;
        cap_dat = bus.dat_o;
      end else if (bus.we_o !== cap_we || bus.adr_o !== cap_adr || bus.dat_o !== cap_dat) begin
        unstable++;
      end
      stb_len++;
    end
    stb_prev = (bus.stb_o === 1'b1);
  end

  // reference model: command-level expected totals
  int         exp_err = 0;
  int         exp_stb = 0;
  int         exp_vld = 0;
  logic [7:0] exp_rd  = 8'h00;
  logic       exp_we;
  logic [7:0] exp_adr, exp_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_i);
    rxd = 1'b0;
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk_i);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk_i);
    rxd = 1'b1;
    repeat (24) @(negedge clk_i);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o !== 1'b0 || bus.stb_o !== 1'b0) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    check({tag, "_idle_bound"}, (n < 1000), 1'b1);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] op, input logic [7:0] adr,
                          input logic [7:0] dat, input logic [7:0] rdata, input int delay);
    ack_delay   = delay;
    slave_rdata = rdata;
    send_byte(op, 1'b1);
    if (op == 8'h57 || op == 8'h52) send_byte(adr, 1'b1);
    if (op == 8'h57) send_byte(dat, 1'b1);
    wait_idle(tag);
    if (op == 8'h57) begin
      exp_stb++; exp_we = 1'b1; exp_adr = adr; exp_dat = dat;
    end else if (op == 8'h52) begin
      exp_stb++; exp_we = 1'b0; exp_adr = adr;
      if (delay == 0) exp_err++;
      else begin exp_vld++; exp_rd = rdata; end
    end else begin
      exp_err++;
    end
    check({tag, "_stb_cnt"}, stb_cnt, exp_stb);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_vld_cnt"}, vld_rise, exp_vld);
    check({tag, "_vld_width"}, vld_hi, exp_vld);
    check({tag, "_rd_dat"}, rd_dat_o, exp_rd);
    check({tag, "_busy"}, busy_o, 1'b0);
    if (op == 8'h57 || op == 8'h52) begin
      check({tag, "_we"}, cap_we, exp_we);
      check({tag, "_adr"}, cap_adr, exp_adr);
      if (op == 8'h57) check({tag, "_dat"}, cap_dat, exp_dat);
    end
  endtask

  initial begin
    logic [7:0] op, a, d, r;
    int e0, s0;

    rst_i = 1'b0;
    rxd   = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rst_stb", bus.stb_o, 1'b0);
    check("rst_we", bus.we_o, 1'b0);
    check("rst_adr", bus.adr_o, 8'h00);
    check("rst_dat", bus.dat_o, 8'h00);
    check("rst_rd_dat", rd_dat_o, 8'h00);
    check("rst_rd_vld", rd_vld_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);

    // low line after reset release must not start a frame
    rst_i = 1'b1;
    repeat (300) @(negedge clk_i);
    check("lowline_err", err_cnt, 0);
    check("lowline_busy", busy_o, 1'b0);
    rxd = 1'b1;
    repeat (40) @(negedge clk_i);

    send_cmd("wr", 8'h57, 8'h31, 8'hA5, 8'h00, 2);
    send_cmd("rd", 8'h52, 8'h80, 8'h00, 8'h3C, 2);
    check("rd_last", last_rd, 8'h3C);

    // broken stop bit on an opcode byte
    send_byte(8'h52, 1'b0);
    repeat (40) @(negedge clk_i);
    exp_err++;
    check("stop_err", err_cnt, exp_err);
    check("stop_stb", stb_cnt, exp_stb);
    check("stop_busy", busy_o, 1'b0);
    send_cmd("rd_after_stop", 8'h52, 8'h10, 8'h00, 8'($urandom), 2);

    send_cmd("badop", 8'h00, 8'h00, 8'h00, 8'h00, 2);

    // 7-cycle glitch
    @(negedge clk_i);
    rxd = 1'b0;
    repeat (7) @(negedge clk_i);
    rxd = 1'b1;
    repeat (200) @(negedge clk_i);
    check("glitch_err", err_cnt, exp_err);
    check("glitch_busy", busy_o, 1'b0);
    check("glitch_stb", stb_cnt, exp_stb);

    send_cmd("timeout", 8'h52, 8'h90, 8'h00, 8'($urandom), 0);
    check("timeout_len", stb_len, 255);

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       op = 8'h57;
        1:       op = 8'h52;
        default: op = 8'($urandom);
      endcase
      send_cmd($sformatf("rand%0d", i), op, 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(1, 6));
    end

    // reset during the address byte
    send_byte(8'h52, 1'b1);
    @(negedge clk_i);
    rxd = 1'b0;
    repeat (40) @(negedge clk_i);
    rst_i = 1'b0;
    rxd   = 1'b1;
    @(negedge clk_i);
    exp_rd = 8'h00;
    check("rsta_stb", bus.stb_o, 1'b0);
    check("rsta_busy", busy_o, 1'b0);
    check("rsta_adr", bus.adr_o, 8'h00);
    check("rsta_dat", bus.dat_o, 8'h00);
    check("rsta_rd_dat", rd_dat_o, 8'h00);
    check("rsta_err", err_o, 1'b0);
    check("rsta_vld", rd_vld_o, 1'b0);
    rst_i = 1'b1;
    e0 = err_cnt;
    s0 = stb_cnt;
    repeat (300) @(negedge clk_i);
    check("rsta_quiet_err", err_cnt, e0);
    check("rsta_quiet_stb", stb_cnt, s0);

    // reset while stb_o waits for an ack
    ack_delay = 0;
    send_byte(8'h52, 1'b1);
    send_byte(8'($urandom), 1'b1);
    check("rstb_stb_high", bus.stb_o, 1'b1);
    exp_stb++;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstb_stb", bus.stb_o, 1'b0);
    check("rstb_we", bus.we_o, 1'b0);
    check("rstb_busy", busy_o, 1'b0);
    check("rstb_adr", bus.adr_o, 8'h00);
    rst_i = 1'b1;
    repeat (300) @(negedge clk_i);
    check("rstb_quiet_err", err_cnt, exp_err);
    check("rstb_quiet_stb", stb_cnt, exp_stb);

    a = 8'($urandom);
    d = 8'($urandom);
    r = 8'($urandom);
    send_cmd("wr_after_rst", 8'h57, a, d, r, 3);
    check("stb_stable", unstable, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
